// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown for the bomb game: loads on entry to the run state, ticks down per second, drains penalties.
// Optional low-time flag on `warn` is built only when COUNTDOWN_WARN_EN is defined.
module bcd_countdown_timer #(
    parameter int          NUM_DIGITS   = 3,
    parameter logic [7:0]  RUN_STATE    = 8'h10,
    parameter logic [7:0]  WIN_STATE    = 8'h20,
    parameter logic [7:0]  LOSE_STATE   = 8'h30,
    parameter int          PENALTY_SECS = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              game_state,
    input  logic                    sec_timer,
    input  logic                    penalty,
    input  logic [4*NUM_DIGITS-1:0] init_time,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    expired,
    output logic                    warn
);

    localparam int         W           = 4 * NUM_DIGITS;
    localparam logic [8:0] PENALTY_ADD = 9'(PENALTY_SECS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN, S_EXPIRED} state_t;

    state_t       state;
    logic [7:0]   pending;
    logic [W-1:0] init_clamped;
    logic [W-1:0] digits_dec;
    logic         borrow;
    logic         dec_zero;
    logic         init_zero;
    logic         pen_drain;
    logic [8:0]   pending_sum;
    logic [7:0]   pending_next;
    logic         low_now;
    logic         low_dec;
    logic         low_init;

    // NOTE: every variable written here gets a value before any conditional path, so no latch is inferred.
    always_comb begin
        init_clamped = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            init_clamped[4*k +: 4] = (init_time[4*k +: 4] > 4'd9) ? 4'd9 : init_time[4*k +: 4];
        end

        // Ripple borrow: lowest nonzero digit drops by one, every digit below it wraps to 9.
        digits_dec = digits;
        borrow     = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (borrow) begin
                if (digits_dec[4*k +: 4] == 4'd0) begin
                    digits_dec[4*k +: 4] = 4'd9;
                end else begin
                    digits_dec[4*k +: 4] = digits_dec[4*k +: 4] - 4'd1;
                    borrow               = 1'b0;
                end
            end
        end

        dec_zero  = (digits_dec == '0);
        init_zero = (init_clamped == '0);

        // Penalty add and one-second drain net in a single saturating update.
        pen_drain    = (game_state == RUN_STATE) && !sec_timer && (pending != 8'd0);
        pending_sum  = {1'b0, pending} + (penalty ? PENALTY_ADD : 9'd0) - {8'd0, pen_drain};
        pending_next = pending_sum[8] ? 8'hFF : pending_sum[7:0];
    end

`ifdef COUNTDOWN_WARN_EN
    function automatic logic low_time(input logic [W-1:0] v);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (v[4*k +: 4] != 4'd0) upper_zero = 1'b0;
        end
        return upper_zero && (v[3:0] != 4'd0);
    endfunction

    always_comb begin
        low_now  = low_time(digits);
        low_dec  = low_time(digits_dec);
        low_init = low_time(init_clamped);
    end
`else
    assign low_now  = 1'b0;
    assign low_dec  = 1'b0;
    assign low_init = 1'b0;
`endif

    // NOTE: all state and outputs use non-blocking assignments; the pulse-style outputs default low each cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            digits  <= '0;
            pending <= 8'd0;
            running <= 1'b0;
            expired <= 1'b0;
            warn    <= 1'b0;
        end else begin
            running <= 1'b0;
            expired <= 1'b0;
            warn    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (game_state == RUN_STATE) begin
                        pending <= 8'd0;
                        if (init_zero) begin
                            digits  <= '0;
                            expired <= 1'b1;
                            state   <= S_EXPIRED;
                        end else begin
                            digits  <= init_clamped;
                            running <= 1'b1;
                            warn    <= low_init;
                            state   <= S_RUN;
                        end
                    end else begin
                        digits <= init_clamped;
                    end
                end

                S_RUN: begin
                    if (game_state == WIN_STATE || game_state == LOSE_STATE) begin
                        pending <= 8'd0;
                        state   <= S_FROZEN;
                    end else if (game_state == RUN_STATE) begin
                        if (sec_timer || pending != 8'd0) begin
                            if (dec_zero) begin
                                digits  <= '0;
                                pending <= 8'd0;
                                expired <= 1'b1;
                                state   <= S_EXPIRED;
                            end else begin
                                digits  <= digits_dec;
                                pending <= pending_next;
                                running <= 1'b1;
                                warn    <= low_dec;
                            end
                        end else begin
                            pending <= pending_next;
                            running <= 1'b1;
                            warn    <= low_now;
                        end
                    end else begin
                        pending <= pending_next;
                        warn    <= low_now;
                    end
                end

                S_FROZEN: begin
                    if (game_state != RUN_STATE && game_state != WIN_STATE &&
                        game_state != LOSE_STATE) begin
                        state <= S_IDLE;
                    end
                end

                S_EXPIRED: begin
                    digits <= '0;
                    if (game_state != RUN_STATE) state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus random stimulus against an
// integer-seconds reference model. Warn expectations follow COUNTDOWN_WARN_EN as seen by this bench.
module tb_bcd_countdown_timer;

    localparam logic [7:0] RUN  = 8'h10;
    localparam logic [7:0] WIN  = 8'h20;
    localparam logic [7:0] LOSE = 8'h30;
    localparam int         PEN  = 10;
`ifdef COUNTDOWN_WARN_EN
    localparam bit WARN_EN = 1'b1;
`else
    localparam bit WARN_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_FROZEN = 2, M_EXP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  gs = 8'h00;
    logic        sec = 1'b0;
    logic        pen = 1'b0;
    logic [11:0] init = 12'h000;
    logic [11:0] digits;
    logic        running, expired, warn;

    int checks = 0;
    int passes = 0;

    int   m_mode = M_IDLE;
    int   m_rem  = 0;
    int   m_pend = 0;
    logic m_run  = 1'b0;
    logic m_exp  = 1'b0;
    logic m_warn = 1'b0;

    logic [14:0] obs;
    logic [14:0] want;

    bcd_countdown_timer #(
        .NUM_DIGITS(3), .RUN_STATE(RUN), .WIN_STATE(WIN), .LOSE_STATE(LOSE), .PENALTY_SECS(PEN)
    ) dut (
        .clk(clk), .reset(reset), .game_state(gs), .sec_timer(sec), .penalty(pen),
        .init_time(init), .digits(digits), .running(running), .expired(expired), .warn(warn)
    );

    always #5 clk = ~clk;

    assign obs = {digits, running, expired, warn};

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic int clamp_secs(input logic [11:0] t);
        int n0, n1, n2;
        n0 = (int'(t[3:0])  > 9) ? 9 : int'(t[3:0]);
        n1 = (int'(t[7:4])  > 9) ? 9 : int'(t[7:4]);
        n2 = (int'(t[11:8]) > 9) ? 9 : int'(t[11:8]);
        return n2 * 100 + n1 * 10 + n0;
    endfunction

    function automatic int sat_add(input int p, input int a);
        return (p + a > 255) ? 255 : p + a;
    endfunction

    // Reference: time remaining is an integer number of seconds; penalties are a seconds backlog.
    task automatic model_edge();
        int  ci;
        bit  dec;
        m_run = 1'b0;
        m_exp = 1'b0;
        ci    = clamp_secs(init);
        case (m_mode)
            M_IDLE: begin
                if (gs == RUN) begin
                    m_pend = 0;
                    if (ci == 0) begin m_rem = 0; m_exp = 1'b1; m_mode = M_EXP; end
                    else begin m_rem = ci; m_run = 1'b1; m_mode = M_RUN; end
                end else m_rem = ci;
            end
            M_RUN: begin
                if (gs == WIN || gs == LOSE) begin
                    m_pend = 0; m_mode = M_FROZEN;
                end else if (gs == RUN) begin
                    dec = 1'b0;
                    if (sec) begin m_rem--; dec = 1'b1; end
                    else if (m_pend > 0) begin m_rem--; m_pend--; dec = 1'b1; end
                    if (pen) m_pend = sat_add(m_pend, PEN);
                    if (dec && m_rem == 0) begin m_pend = 0; m_exp = 1'b1; m_mode = M_EXP; end
                    else m_run = 1'b1;
                end else if (pen) begin
                    m_pend = sat_add(m_pend, PEN);
                end
            end
            M_FROZEN: if (gs != RUN && gs != WIN && gs != LOSE) m_mode = M_IDLE;
            default: begin
                m_rem = 0;
                if (gs != RUN) m_mode = M_IDLE;
            end
        endcase
        m_warn = WARN_EN && (m_mode == M_RUN) && (m_rem >= 1) && (m_rem <= 9);
        want   = {to_bcd(m_rem), m_run, m_exp, m_warn};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic go_idle();
        sec = 1'b0; pen = 1'b0;
        gs = WIN;  tick();
        gs = 8'h00; tick(); tick();
    endtask

    task automatic load(input logic [11:0] t);
        go_idle();
        init = t; gs = RUN; tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        want = 15'h0;
        checks++;
        if (obs !== want) $display("FAIL reset: got %h want %h", obs, want);
        else passes++;
        m_mode = M_IDLE; m_rem = 0; m_pend = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic_count();
        init = 12'h120; gs = 8'h00; tick();
        checks++;
        if (obs !== want) $display("FAIL idle_track: got %h want %h", obs, want); else passes++;
        gs = RUN; tick();
        checks++;
        if (obs !== want) $display("FAIL load: got %h want %h", obs, want); else passes++;
        for (int i = 0; i < 3; i++) begin
            sec = 1'b1; tick();
            checks++;
            if (obs !== want) $display("FAIL count[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        sec = 1'b0;
        checks++;
        if (digits !== 12'h117 || running !== 1'b1)
            $display("FAIL count_end: got %h/%b want 117/1", digits, running);
        else passes++;
    endtask

    task automatic test_borrow_expiry();
        int pulses;
        load(12'h100);
        sec = 1'b1; tick(); sec = 1'b0;
        checks++;
        if (digits !== 12'h099 || obs !== want) $display("FAIL borrow_100: got %h want %h", obs, want);
        else passes++;
        load(12'h001);
        pulses = 0;
        sec = 1'b1; tick();
        if (expired) pulses++;
        checks++;
        if (obs !== want || digits !== 12'h000) $display("FAIL expire: got %h want %h", obs, want);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (expired) pulses++;
            checks++;
            if (obs !== want) $display("FAIL post_expire[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        sec = 1'b0;
        checks++;
        if (pulses != 1) $display("FAIL expire_pulses: got %0d want 1", pulses); else passes++;
    endtask

    task automatic test_penalty();
        int pulses;
        load(12'h045);
        pen = 1'b1; tick(); pen = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tick();
            checks++;
            if (obs !== want) $display("FAIL drain[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        checks++;
        if (digits !== 12'h035) $display("FAIL drain_end: got %h want 035", digits); else passes++;
        load(12'h005);
        pulses = 0;
        pen = 1'b1; tick(); pen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (expired) pulses++;
            checks++;
            if (obs !== want) $display("FAIL pen_expire[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        checks++;
        if (pulses != 1 || digits !== 12'h000)
            $display("FAIL pen_expire_pulse: got %0d/%h want 1/000", pulses, digits);
        else passes++;
        // Backlog must be gone: a fresh load has to hold without ticks.
        load(12'h030);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (digits !== 12'h030) $display("FAIL pend_cleared: got %h want 030", digits); else passes++;
    endtask

    task automatic test_saturation();
        load(12'h999);
        gs = 8'h00;
        pen = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        pen = 1'b0;
        gs = RUN;
        for (int i = 0; i < 260; i++) begin
            tick();
            checks++;
            if (obs !== want) $display("FAIL sat[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        checks++;
        if (digits !== 12'h744) $display("FAIL sat_end: got %h want 744", digits); else passes++;
    endtask

    task automatic test_pause_freeze();
        load(12'h050);
        gs = 8'h00;
        for (int i = 0; i < 5; i++) begin
            sec = 1'b1; tick();
            checks++;
            if (obs !== want) $display("FAIL pause[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        gs = RUN;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== want) $display("FAIL resume[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        gs = WIN;
        for (int i = 0; i < 3; i++) begin
            pen = (i == 1); tick();
            checks++;
            if (obs !== want) $display("FAIL frozen[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        pen = 1'b0; sec = 1'b0;
        init = 12'h2C7;
        gs = 8'h00; tick(); tick();
        checks++;
        if (digits !== 12'h297 || obs !== want) $display("FAIL unfreeze: got %h want %h", obs, want);
        else passes++;
    endtask

    task automatic test_clamp_async_reset();
        load(12'hAF3);
        checks++;
        if (digits !== 12'h993 || obs !== want) $display("FAIL clamp: got %h want %h", obs, want);
        else passes++;
        sec = 1'b1; tick(); tick(); sec = 1'b0;
        #2 reset = 1'b0;
        #1;
        want = 15'h0;
        checks++;
        if (obs !== want) $display("FAIL async_reset: got %h want %h", obs, want); else passes++;
        m_mode = M_IDLE; m_rem = 0; m_pend = 0;
        #1 reset = 1'b1;
        gs = 8'h00; init = 12'h321; tick();
        checks++;
        if (obs !== want) $display("FAIL after_reset: got %h want %h", obs, want); else passes++;
    endtask

    task automatic test_warn();
        logic [2:0] seen;
        load(12'h011);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin sec = 1'b1; tick(); sec = 1'b0; end
            seen[i] = warn;
            checks++;
            if (obs !== want) $display("FAIL warn_seq[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        checks++;
        if (seen !== (WARN_EN ? 3'b100 : 3'b000))
            $display("FAIL warn_pattern: got %b want %b", seen, WARN_EN ? 3'b100 : 3'b000);
        else passes++;
        sec = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        sec = 1'b0;
        checks++;
        if (digits !== 12'h000 || warn !== 1'b0) $display("FAIL warn_zero: got %h/%b want 000/0", digits, warn);
        else passes++;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            gs = (r <= 5) ? RUN : (r == 6) ? WIN : (r == 7) ? LOSE : (r == 8) ? 8'h00 : 8'h05;
            sec = ($urandom_range(0, 2) == 0);
            pen = ($urandom_range(0, 12) == 0);
            if ($urandom_range(0, 1) == 1) init = 12'($urandom);
            else init = {8'h00, 4'($urandom_range(0, 12))};
            tick();
            checks++;
            if (obs !== want) $display("FAIL random[%0d]: got %h want %h", i, obs, want); else passes++;
        end
        sec = 1'b0; pen = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_borrow_expiry();
        test_penalty();
        test_saturation();
        test_pause_freeze();
        test_clamp_async_reset();
        test_warn();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
